// File: rtl/picorv32_mem_responder_if.sv
// PicoRV32 native memory bus between a core (master) and a memory responder (slave).
// One request is held on mem_valid until the single-cycle mem_ready strobe; err rides with mem_ready.
interface picorv32_mem_responder_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        err;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata, err
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata, err
  );
endinterface

// File: rtl/picorv32_mem_responder.sv
// Word-array memory slave for the PicoRV32 native bus with runtime wait states and range checking.
// Define MEM_RESP_STATS_EN to build the saturating fetch/read/write counters; otherwise they read 0.
module picorv32_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LAT_WIDTH  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  picorv32_mem_responder_if.slave bus,
  input  logic [LAT_WIDTH-1:0]   wait_instr,
  input  logic [LAT_WIDTH-1:0]   wait_data,
  input  logic                   stats_clr,
  output logic [CNT_WIDTH-1:0]   fetch_count,
  output logic [CNT_WIDTH-1:0]   rd_count,
  output logic [CNT_WIDTH-1:0]   wr_count,
  output logic [1:0]             dbg_state_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [LAT_WIDTH-1:0]  wcnt_q, wcnt_d;
  logic [29:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  instr_q, instr_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [31:0]           mem [DEPTH];

  logic [LAT_WIDTH-1:0]  w_sel;
  logic [29:0]           sel_addr;
  logic [3:0]            sel_wstrb;
  logic                  sel_oor;
  logic [31:0]           mem_word;
  logic                  enter_resp;
  logic                  resp_ok;
  logic [1:0]            unused_addr_lo;

  assign unused_addr_lo = bus.mem_addr[1:0];

  // In IDLE the request has not been captured yet, so a zero-wait access looks at the bus directly.
  assign sel_addr  = (state_q == ST_IDLE) ? bus.mem_addr[31:2] : addr_q;
  assign sel_wstrb = (state_q == ST_IDLE) ? bus.mem_wstrb      : wstrb_q;
  assign sel_oor   = (sel_addr >> ADDR_WIDTH) != 30'd0;
  assign mem_word  = mem[sel_addr[ADDR_WIDTH-1:0]];
  assign w_sel     = bus.mem_instr ? wait_instr : wait_data;

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    instr_d    = instr_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.mem_valid) begin
          addr_d  = bus.mem_addr[31:2];
          wdata_d = bus.mem_wdata;
          wstrb_d = bus.mem_wstrb;
          instr_d = bus.mem_instr;
          if (w_sel == '0) begin
            enter_resp = 1'b1;
          end else begin
            wcnt_d  = w_sel;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!bus.mem_valid) begin
          wcnt_d  = '0;
          state_d = ST_IDLE;
        end else if (wcnt_q == LAT_WIDTH'(1)) begin
          wcnt_d     = '0;
          enter_resp = 1'b1;
        end else begin
          wcnt_d = wcnt_q - LAT_WIDTH'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        rdata_d = 32'd0;
        err_d   = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (enter_resp) begin
      state_d = ST_RESP;
      err_d   = sel_oor;
      rdata_d = (!sel_oor && sel_wstrb == 4'd0) ? mem_word : 32'd0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      instr_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      instr_q <= instr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // err_q holds the range check of the captured address for the whole RESP cycle.
  assign resp_ok = (state_q == ST_RESP) && !err_q;

  always_ff @(posedge clk) begin
    if (resp_ok && wstrb_q != 4'd0) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) begin
          mem[addr_q[ADDR_WIDTH-1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign bus.mem_ready = (state_q == ST_RESP);
  assign bus.mem_rdata = rdata_q;
  assign bus.err       = err_q;
  assign dbg_state_o   = state_q;

`ifdef MEM_RESP_STATS_EN
  logic [CNT_WIDTH-1:0] fetch_cnt_q, rd_cnt_q, wr_cnt_q;
  logic                 fetch_inc, rd_inc, wr_inc;

  assign wr_inc    = resp_ok && (wstrb_q != 4'd0);
  assign fetch_inc = resp_ok && (wstrb_q == 4'd0) && instr_q;
  assign rd_inc    = resp_ok && (wstrb_q == 4'd0) && !instr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_cnt_q <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
    end else if (stats_clr) begin
      fetch_cnt_q <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
    end else begin
      if (fetch_inc && fetch_cnt_q != '1) fetch_cnt_q <= fetch_cnt_q + CNT_WIDTH'(1);
      if (rd_inc && rd_cnt_q != '1)       rd_cnt_q    <= rd_cnt_q + CNT_WIDTH'(1);
      if (wr_inc && wr_cnt_q != '1)       wr_cnt_q    <= wr_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign rd_count    = rd_cnt_q;
  assign wr_count    = wr_cnt_q;
`else
  logic unused_stats_clr;

  assign unused_stats_clr = stats_clr;
  assign fetch_count      = '0;
  assign rd_count         = '0;
  assign wr_count         = '0;
`endif

endmodule
